// File: rtl/godai_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// godai_trace_buffer_if
// Purpose : Read-side bus of the trace FIFO. It carries the head entry and the
//           valid/ready handshake from the buffer (master) to the consumer
//           (slave).
// Signals : trace_valid_o  - head entry available (master -> slave)
//           trace_ready_i  - consumer accepts head entry (slave -> master)
//           trace_event_o  - head event vector, NUM_EVENTS bits
//           trace_pc_o     - head PC, ADDR_WIDTH bits
//           trace_ts_o     - head timestamp, TS_WIDTH bits
// ---------------------------------------------------------------------------
interface godai_trace_buffer_if #(
    parameter int NUM_EVENTS = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int TS_WIDTH   = 16
);
    logic                  trace_valid_o;
    logic                  trace_ready_i;
    logic [NUM_EVENTS-1:0] trace_event_o;
    logic [ADDR_WIDTH-1:0] trace_pc_o;
    logic [TS_WIDTH-1:0]   trace_ts_o;

    modport master (
        output trace_valid_o,
        output trace_event_o,
        output trace_pc_o,
        output trace_ts_o,
        input  trace_ready_i
    );

    modport slave (
        input  trace_valid_o,
        input  trace_event_o,
        input  trace_pc_o,
        input  trace_ts_o,
        output trace_ready_i
    );
endinterface

// File: rtl/godai_trace_buffer.sv
// ---------------------------------------------------------------------------
// godai_trace_buffer
// Purpose : Captures core trace events ({event vector, PC, timestamp}) into a
//           first-word-fall-through FIFO that a consumer drains over a
//           valid/ready interface. A free-running timestamp stamps each entry.
//           Pushes arriving while the FIFO is full and not popping are dropped
//           and latch a sticky overflow flag.
// Ports   : clk          - clock, rising edge
//           rst_n        - synchronous active-low reset
//           trace_en_i   - capture enable
//           clear_i      - synchronous flush of FIFO and overflow flag
//           event_i      - per-cycle event strobes
//           event_mask_i - per-event capture mask (GODAI_TRACE_FILTER_EN only)
//           pc_i         - core PC sampled with the events
//           trace        - read-side bus (godai_trace_buffer_if.master)
//           count_o      - current occupancy, 0..DEPTH
//           overflow_o   - sticky dropped-entry flag
// Config  : define GODAI_TRACE_FILTER_EN to add event_mask_i; the recorded
//           vector becomes event_i & event_mask_i.
// ---------------------------------------------------------------------------
module godai_trace_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_EVENTS = 5,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        trace_en_i,
    input  logic                        clear_i,
    input  logic [NUM_EVENTS-1:0]       event_i,
`ifdef GODAI_TRACE_FILTER_EN
    input  logic [NUM_EVENTS-1:0]       event_mask_i,
`endif
    input  logic [ADDR_WIDTH-1:0]       pc_i,
    godai_trace_buffer_if.master        trace,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        overflow_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = NUM_EVENTS + ADDR_WIDTH + TS_WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;

    logic [NUM_EVENTS-1:0] rec_vec;
    logic                  empty, full;
    logic                  push_req, push, pop, drop;
    logic [ENTRY_W-1:0]    head;

    always_comb begin
`ifdef GODAI_TRACE_FILTER_EN
        rec_vec = event_i & event_mask_i;
`else
        rec_vec = event_i;
`endif
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        push_req = trace_en_i & ~clear_i & (|rec_vec);
        pop      = ~empty & trace.trace_ready_i & ~clear_i;
        // A full FIFO can still take a push when the head leaves this cycle:
        // the write lands in the slot being vacated.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        // Timestamp keeps running through clear; it wraps naturally.
        ts_d       = ts_q + TS_WIDTH'(1);

        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ts_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ts_q       <= ts_d;
        end
    end

    // Storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {rec_vec, pc_i, ts_q};
        end
    end

    // Head fields are forced to zero whenever nothing is valid.
    always_comb begin
        head                = mem_q[rd_ptr_q];
        trace.trace_valid_o = ~empty;
        trace.trace_event_o = '0;
        trace.trace_pc_o    = '0;
        trace.trace_ts_o    = '0;
        if (!empty) begin
            trace.trace_event_o = head[ENTRY_W-1 -: NUM_EVENTS];
            trace.trace_pc_o    = head[TS_WIDTH +: ADDR_WIDTH];
            trace.trace_ts_o    = head[TS_WIDTH-1:0];
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
